// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared types and constants for the RV32I pipeline front end.
//   XLEN               - datapath width
//   DEFAULT_RESET_PC   - PC loaded on reset unless a stage overrides it
//   DEFAULT_NOP_INSTR  - addi x0,x0,0, shown to F/D whenever fetch has nothing valid
//   fetch_state_t      - IF stage control states
//   alignWord()        - clears address bits [1:0] (no misaligned fetches exist)
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    // S_REQ : request outstanding at PCF
    // S_HOLD: instruction captured while the pipe was stalled
    // S_DROP: a redirected-away request is still waiting for its ack
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg
// Program counter register of the IF stage.
//   clk      in   clock
//   rst      in   synchronous active-high reset, loads RESET_PC
//   load     in   redirect: take target (word aligned), wins over advance
//   target   in   redirect address
//   advance  in   step to pc+4
//   pc       out  current PC, bits [1:0] always zero
//   pcPlus4  out  pc+4, wraps modulo 2^XLEN
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4
);

    // Redirects beat sequential advance; with neither the PC simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= alignWord(RESET_PC);
        end else if (load) begin
            pc <= alignWord(target);
        end else if (advance) begin
            pc <= pcPlus4;
        end
    end

    // Plain XLEN-bit add, so 0xFFFF_FFFC + 4 wraps to 0.
    assign pcPlus4 = pc + XLEN'(4);

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// IF stage of the 5-stage RV32I pipeline. Owns PCF, fetches from a
// variable-latency instruction memory over req/ack, holds a fetched
// instruction across stalls and discards fetches killed by EX redirects.
//   clk          in   clock
//   rst          in   synchronous active-high reset (shared with imem)
//   StallF       in   hold current instruction/PC
//   PCSrcE       in   redirect from EX
//   PCTargetE    in   redirect target (bits [1:0] ignored)
//   ImemReq      out  fetch request, held with stable ImemAddr until ImemAck
//   ImemAddr     out  fetch address
//   ImemAck      in   one-cycle pulse, ImemRdata valid
//   ImemRdata    in   fetched instruction
//   InstrF       out  instruction to F/D (NOP_INSTR when not valid)
//   PCF          out  PC of InstrF
//   PCPlus4F     out  PCF+4
//   FetchValidF  out  InstrF/PCF valid this cycle
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemAck,
    input  logic [XLEN-1:0] ImemRdata,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            FetchValidF
);

    fetch_state_t    state;
    fetch_state_t    stateNext;
    logic [XLEN-1:0] holdBuf;
    logic [XLEN-1:0] dropAddr;
    logic            pcLoad;
    logic            pcAdvance;
    logic            bufLoad;
    logic            dropLoad;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) pcReg (
        .clk     (clk),
        .rst     (rst),
        .load    (pcLoad),
        .target  (PCTargetE),
        .advance (pcAdvance),
        .pc      (PCF),
        .pcPlus4 (PCPlus4F)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= stateNext;
        end
    end

    // The hold buffer keeps an instruction that arrived while F/D was not
    // enabled. dropAddr remembers the address of a request that a redirect
    // killed before its ack: the handshake forbids moving ImemAddr until
    // that ack shows up, even though PCF has already jumped.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdBuf  <= NOP_INSTR;
            dropAddr <= alignWord(RESET_PC);
        end else begin
            if (bufLoad) begin
                holdBuf <= ImemRdata;
            end
            if (dropLoad) begin
                dropAddr <= PCF;
            end
        end
    end

    // Next state, PC control and all outputs. Reset silences the request
    // and the valid flag; a redirect beats a stall in every state and
    // always turns the current cycle into a bubble.
    always_comb begin
        stateNext   = state;
        pcLoad      = 1'b0;
        pcAdvance   = 1'b0;
        bufLoad     = 1'b0;
        dropLoad    = 1'b0;
        ImemReq     = 1'b0;
        ImemAddr    = PCF;
        FetchValidF = 1'b0;
        InstrF      = NOP_INSTR;

        if (!rst) begin
            case (state)
                S_REQ: begin
                    ImemReq = 1'b1;
                    if (PCSrcE) begin
                        pcLoad = 1'b1;
                        // Without the ack the request is still in flight and
                        // has to be drained before fetching at the target.
                        if (!ImemAck) begin
                            dropLoad  = 1'b1;
                            stateNext = S_DROP;
                        end
                    end else if (ImemAck) begin
                        FetchValidF = 1'b1;
                        InstrF      = ImemRdata;
                        if (StallF) begin
                            bufLoad   = 1'b1;
                            stateNext = S_HOLD;
                        end else begin
                            pcAdvance = 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (PCSrcE) begin
                        pcLoad    = 1'b1;
                        stateNext = S_REQ;
                    end else begin
                        FetchValidF = 1'b1;
                        InstrF      = holdBuf;
                        if (!StallF) begin
                            pcAdvance = 1'b1;
                            stateNext = S_REQ;
                        end
                    end
                end

                S_DROP: begin
                    ImemReq  = 1'b1;
                    ImemAddr = dropAddr;
                    if (PCSrcE) begin
                        pcLoad = 1'b1;
                    end
                    if (ImemAck) begin
                        stateNext = S_REQ;
                    end
                end

                default: begin
                    stateNext = S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stall/redirect/reset traffic against a
// behavioural model, with a randomized-latency instruction memory whose
// contents are a fixed function of the address.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        FetchValidF;

    int errors = 0;
    int checks = 0;

    fetch_stage #(
        .RESET_PC  (RPC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemAck     (ImemAck),
        .ImemRdata   (ImemRdata),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .FetchValidF (FetchValidF)
    );

    always #5 clk = ~clk;

    // Program memory contents: a scrambled function of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Instruction memory model state.
    int          fixedLat  = 0;
    logic        lastReq   = 1'b0;
    logic        lastAck   = 1'b0;
    logic [31:0] lastAddr  = '0;
    logic        imPending = 1'b0;
    int          imCnt     = 0;
    logic [31:0] imAddr    = '0;

    // One clock cycle: drive the pipeline inputs and the memory's response
    // just after the edge, then sample the request at the falling edge.
    // A request seen last cycle starts a 0..2 extra-cycle countdown, so
    // the ack always comes at least one cycle after the request.
    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic [31:0] t);
        @(posedge clk);
        #1;
        rst       = r;
        StallF    = s;
        PCSrcE    = p;
        PCTargetE = t;
        ImemAck   = 1'b0;
        ImemRdata = $urandom;
        if (r || lastAck) imPending = 1'b0;
        if (!r) begin
            if (imPending) begin
                imCnt--;
            end else if (lastReq && !lastAck) begin
                imPending = 1'b1;
                imAddr    = lastAddr;
                imCnt     = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 2));
            end
            if (imPending && imCnt == 0) begin
                ImemAck   = 1'b1;
                ImemRdata = memWord(imAddr);
            end
        end
        @(negedge clk);
        lastReq  = ImemReq;
        lastAddr = ImemAddr;
        lastAck  = ImemAck;
    endtask

    // Behavioural model: the PC of the next instruction to deliver, whether
    // a delivered-but-not-consumed instruction is held, and whether an old
    // request still has to be drained (and at which address).
    logic [31:0] mPc        = '0;
    logic [31:0] mStaleAddr = '0;
    logic        mHeld      = 1'b0;
    logic        mStale     = 1'b0;
    logic        mKnown     = 1'b0;
    logic        expReq;
    logic        expValid;
    logic [31:0] expAddr;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checkOutput("rstReq", ImemReq, 32'd0);
            checkOutput("rstValid", FetchValidF, 32'd0);
            checkOutput("rstInstr", InstrF, NOP);
            if (mKnown) begin
                checkOutput("pcF", PCF, mPc);
                checkOutput("pcPlus4F", PCPlus4F, mPc + 32'd4);
            end
            mPc    = RPC;
            mHeld  = 1'b0;
            mStale = 1'b0;
            mKnown = 1'b1;
        end else if (mKnown) begin
            expReq   = !mHeld;
            expAddr  = mStale ? mStaleAddr : mPc;
            expValid = !PCSrcE && (mHeld || (!mStale && ImemAck));
            checkOutput("pcF", PCF, mPc);
            checkOutput("pcPlus4F", PCPlus4F, mPc + 32'd4);
            checkOutput("imemReq", ImemReq, {31'd0, expReq});
            if (expReq) checkOutput("imemAddr", ImemAddr, expAddr);
            checkOutput("fetchValid", FetchValidF, {31'd0, expValid});
            checkOutput("instrF", InstrF, expValid ? memWord(mPc) : NOP);

            if (PCSrcE) begin
                if (mStale) begin
                    if (ImemAck) mStale = 1'b0;
                end else if (!mHeld && !ImemAck) begin
                    mStale     = 1'b1;
                    mStaleAddr = mPc;
                end
                mHeld = 1'b0;
                mPc   = PCTargetE & ~32'd3;
            end else if (mStale) begin
                if (ImemAck) mStale = 1'b0;
            end else if (expValid) begin
                if (StallF) begin
                    mHeld = 1'b1;
                end else begin
                    mHeld = 1'b0;
                    mPc   = mPc + 32'd4;
                end
            end
        end
    end

    logic        rndRst;
    logic        rndStall;
    logic        rndRedir;
    logic [31:0] rndTarget;

    initial begin
        rst       = 1'b1;
        StallF    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        ImemAck   = 1'b0;
        ImemRdata = '0;

        // Reset
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("litRstReq", ImemReq, 32'd0);
        checkOutput("litRstInstr", InstrF, NOP);

        // Sequential fetch, memory acks one cycle after each request
        fixedLat = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("seqAddr", ImemAddr, 32'(4 * (i / 2)));
            checkOutput("seqValid", FetchValidF, 32'(i % 2));
            checkOutput("seqPlus4", PCPlus4F, 32'(4 * (i / 2) + 4));
        end

        // Ack at 0x10 while stalled for three cycles
        applyStimulus(0, 1, 0, 0);
        checkOutput("stallAckValid", FetchValidF, 32'd1);
        checkOutput("stallAckInstr", InstrF, memWord(32'h10));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("holdReq", ImemReq, 32'd0);
            checkOutput("holdInstr", InstrF, memWord(32'h10));
            checkOutput("holdPc", PCF, 32'h10);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("releaseValid", FetchValidF, 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("afterHoldAddr", ImemAddr, 32'h14);
        checkOutput("afterHoldReq", ImemReq, 32'd1);

        // Redirect to 0x100 while the request to 0x20 is pending
        repeat (6) applyStimulus(0, 0, 0, 0);
        checkOutput("pendAddr", ImemAddr, 32'h20);
        fixedLat = 2;
        applyStimulus(0, 0, 1, 32'h100);
        checkOutput("redirValid", FetchValidF, 32'd0);
        checkOutput("redirAddr", ImemAddr, 32'h20);
        applyStimulus(0, 0, 0, 0);
        checkOutput("dropAddr", ImemAddr, 32'h20);
        checkOutput("dropPc", PCF, 32'h100);
        applyStimulus(0, 0, 0, 0);
        checkOutput("dropAckValid", FetchValidF, 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("targetAddr", ImemAddr, 32'h100);

        // Ack and redirect to 0x200 in the same cycle
        fixedLat = 0;
        applyStimulus(0, 0, 1, 32'h200);
        checkOutput("ackRedirValid", FetchValidF, 32'd0);
        checkOutput("ackRedirInstr", InstrF, NOP);

        // Redirect to 0xFFFF_FFFE: aligned to 0xFFFF_FFFC, then wraps to 0
        applyStimulus(0, 0, 1, 32'hFFFF_FFFE);
        checkOutput("addr200", ImemAddr, 32'h200);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrapPc", PCF, 32'hFFFF_FFFC);
        checkOutput("wrapPlus4", PCPlus4F, 32'h0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrapAddr", ImemAddr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrapInstr", InstrF, memWord(32'hFFFF_FFFC));
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrappedAddr", ImemAddr, 32'h0);

        // Reset while holding an instruction at PC 4
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("rstHoldReq", ImemReq, 32'd0);
        checkOutput("rstHoldValid", FetchValidF, 32'd0);
        checkOutput("rstHoldInstr", InstrF, NOP);
        checkOutput("rstHoldPc", PCF, 32'h4);
        applyStimulus(0, 0, 0, 0);
        checkOutput("postRstAddr", ImemAddr, RPC);
        checkOutput("postRstValid", FetchValidF, 32'd0);

        // Reset while draining a killed request
        fixedLat = 2;
        applyStimulus(0, 0, 1, 32'h300);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rstDropInstr", InstrF, NOP);
        applyStimulus(0, 0, 0, 0);
        checkOutput("postDropRstAddr", ImemAddr, RPC);
        checkOutput("postDropRstPc", PCF, RPC);
        checkOutput("postDropRstValid", FetchValidF, 32'd0);

        // Randomized traffic
        fixedLat = -1;
        for (int n = 0; n < 4000; n++) begin
            rndRst   = ($urandom_range(0, 199) == 0);
            rndStall = ($urandom_range(0, 99) < 30);
            rndRedir = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 7) == 0) begin
                rndTarget = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            end else begin
                rndTarget = $urandom;
            end
            applyStimulus(rndRst, rndStall, rndRedir, rndTarget);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
